serial_match_scheduler: RTL and testbench
=========================================

# serial_match_scheduler

Shares one serial "0-then-1" Moore pattern detector among NREQ requesters. Each requester offers a W-bit word; the scheduler grants requesters round-robin, shifts the granted word LSB-first through the detector, and counts detections. It returns one result per word, tagged with the requester id. It sits between the requester ports and the serial-detection datapath, and is the only block that drives the detector's input and reset.

## Interface
- NREQ, 4: number of requesters (≥2)
- W, 8: word width in bits (≥2)
- IDW, $clog2(NREQ): width of the requester id
- CW, $clog2(W+1): width of the detection count
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*W  packed words; requester i occupies bits [i*W +: W]
- req_ready  out  NREQ  one-hot accept pulse to the granted requester
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_id  out  IDW  requester index for the result
- res_count  out  CW  number of detections in the word
- busy  out  1  high in every state except IDLE

## Operation
- Controller states: IDLE, LOAD, SHIFT, REPORT.
- IDLE
  - If any req_valid is high, grant the first valid requester searching from rr_ptr+1 modulo NREQ, register it as g, and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD
  - req_ready[g]=1 for exactly this cycle.
  - Capture req_data[g] into the shift register.
  - Clear the bit counter and the detection count.
  - Force the detector to state A.
  - Go to SHIFT.
- SHIFT (W cycles)
  - Each cycle, feed shift-register bit 0 as detector input x, shift right, and increment the bit counter.
  - After the W-th bit, go to REPORT.
- Detector (Moore; states A, B, C, D)
  - A: x=0 → B, x=1 → A.
  - B: x=0 → B, x=1 → C.
  - C → D unconditionally.
  - D → A unconditionally.
  - Detector output y is 1 in A and D, 0 in B and C. y is internal only.
- Counting: res_count increments in any SHIFT cycle whose detector next-state is C, so the final bit is included. Width CW never overflows because count ≤ W.
- REPORT
  - res_valid=1; res_id=g and res_count are held stable.
  - When res_ready is high, set rr_ptr=g and go to IDLE.
- Requester protocol
  - A requester holds req_valid and req_data stable until it sees req_ready.
  - If req_valid falls between IDLE and LOAD, the word is still captured. This is a protocol violation and is not checked.
- Reset values
  - State IDLE, rr_ptr=NREQ-1 (requester 0 has first priority), detector in A.
  - req_ready=0, res_valid=0, res_id=0, res_count=0, busy=0.
- Reset mid-operation: the state returns to IDLE immediately. The in-flight word is dropped and no result is produced.

## Timing
- Grant decision in cycle 0 (IDLE), req_ready in cycle 1 (LOAD), SHIFT in cycles 2..W+1, res_valid first high in cycle W+2.
- Minimum spacing between accepted words is W+3 cycles (res_ready tied high).
- res_valid stays high, with res_id and res_count stable, until the cycle in which res_ready=1; it drops the next cycle.
- req_ready is never asserted outside LOAD and never asserted for more than one requester.
- A request that arrives while the block is busy waits; it is arbitrated on the next IDLE cycle.
- rr_ptr updates only on result handoff.

## Structure
- Package serial_match_pkg holds:
  - the controller state enum {IDLE, LOAD, SHIFT, REPORT};
  - the detector state enum {A, B, C, D};
  - the round-robin pick function.
- One sub-module, seq_detect_core, contains the detector. Ports: clk, rst_n, clr, en, x, next_is_c, y. Advancing is gated by en.
- The controller, round-robin pointer, shift register and counters live in the top module.

## Test plan
- Reset release with no requests: busy=0, res_valid=0, req_ready=0 for 20 cycles.
- Single requester 0 with data 8'hAA: req_ready[0] pulses in cycle 1; res_valid in cycle 10 with res_id=0, res_count=2.
- Data words 8'hFF and 8'h00 each give res_count=0; 8'h66 gives res_count=2; 8'h02 gives res_count=1.
- All four requesters held valid: grant order is 0,1,2,3,0. No req_ready overlaps.
- res_ready held low for 5 cycles in REPORT: res_valid, res_id and res_count stay stable. No new req_ready is issued until handoff.
- rst_n asserted in the middle of SHIFT: all outputs return to their reset values in the same cycle. After release, the pending requester 0 is re-granted and gets the correct count.

Source files
------------

// File: rtl/serial_match_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_match_pkg
//  Description : Shared types for the serial match scheduler: controller
//                state encoding, detector state encoding and the round-robin
//                requester pick function.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_match_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        A = 2'd0,
        B = 2'd1,
        C = 2'd2,
        D = 2'd3
    } det_state_t;

    // Returns the first set bit of 'valid' searching upward from ptr+1
    // modulo nreq. The loop runs from the farthest candidate to the nearest,
    // so the nearest valid requester is the last (winning) assignment.
    // Returns 0 when nothing is valid; callers qualify with an any-valid flag.
    function automatic int rr_pick(input logic [31:0] valid,
                                   input int          ptr,
                                   input int          nreq);
        int          pick;
        int          idx;
        logic [31:0] sh;
        pick = 0;
        for (int k = nreq; k >= 1; k--) begin
            idx = (ptr + k) % nreq;
            sh  = valid >> idx;
            if (sh[0]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_match_scheduler_seq_detect_core.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_core
//  Description : Moore "0-then-1" serial pattern detector.
//                A: 0->B 1->A   B: 0->B 1->C   C->D   D->A
//                y is high in A and D.
//  Ports       : clk, rst_n  - clock, async active-low reset (to A)
//                clr         - synchronous force to A (wins over en)
//                en          - advance on x this cycle
//                x           - serial input bit
//                next_is_c   - combinational: next state would be C
//                y           - Moore output
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_core
    import serial_match_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic next_is_c,
    output logic y
);

    det_state_t r_state;
    det_state_t w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            A:       w_next = x ? A : B;
            B:       w_next = x ? C : B;
            C:       w_next = D;
            D:       w_next = A;
            default: w_next = A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= A;
        end else if (clr) begin
            r_state <= A;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    assign next_is_c = (w_next == C);
    assign y         = (r_state == A) || (r_state == D);

endmodule
`default_nettype wire

// File: rtl/serial_match_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : serial_match_scheduler
//  Description : Round-robin shares one serial pattern detector among NREQ
//                requesters. The granted W-bit word is shifted LSB-first
//                through the detector; detections are counted and returned
//                as one result per word, tagged with the requester id.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                req_valid/req_data   - per-requester word offer
//                req_ready            - one-hot accept pulse (LOAD cycle)
//                res_valid/res_ready  - result handshake
//                res_id, res_count    - requester index, detection count
//                busy                 - controller not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_match_scheduler
    import serial_match_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = $clog2(NREQ),
    parameter int CW   = $clog2(W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic [CW-1:0]     res_count,
    output logic              busy
);

    ctrl_state_t     r_state;
    ctrl_state_t     w_next_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_grant;
    logic [W-1:0]    r_shift;
    logic [CW-1:0]   r_bit_cnt;
    logic [CW-1:0]   r_count;
    logic [IDW-1:0]  w_pick;
    logic            w_any;
    logic            w_last_bit;
    logic            w_next_is_c;
    logic            w_det_y_unused;
    logic [NREQ-1:0] w_req_ready;

    assign w_any      = |req_valid;
    assign w_pick     = IDW'(rr_pick(32'(req_valid), int'(r_rr_ptr), NREQ));
    assign w_last_bit = (r_bit_cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any)      w_next_state = LOAD;
            LOAD:                    w_next_state = SHIFT;
            SHIFT:   if (w_last_bit) w_next_state = REPORT;
            REPORT:  if (res_ready)  w_next_state = IDLE;
            default:                 w_next_state = IDLE;
        endcase
    end

    // Datapath: grant capture, word load, serial shift and counting.
    // The pointer only moves at result handoff so a stalled consumer
    // cannot skew fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= IDW'(NREQ - 1);
            r_grant   <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                    end
                end
                LOAD: begin
                    r_shift   <= req_data[r_grant*W +: W];
                    r_bit_cnt <= '0;
                    r_count   <= '0;
                end
                SHIFT: begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    // Counting on the detector's next state includes the
                    // final bit of the word.
                    if (w_next_is_c) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        r_rr_ptr <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    seq_detect_core u_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (r_state == LOAD),
        .en        (r_state == SHIFT),
        .x         (r_shift[0]),
        .next_is_c (w_next_is_c),
        .y         (w_det_y_unused)
    );

    always_comb begin
        w_req_ready = '0;
        if (r_state == LOAD) begin
            w_req_ready[r_grant] = 1'b1;
        end
    end

    assign req_ready = w_req_ready;
    assign res_valid = (r_state == REPORT);
    assign res_id    = r_grant;
    assign res_count = r_count;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_match_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_match_scheduler
//  Description : Scoreboard bench for serial_match_scheduler. Stimulus pushes
//                hand-computed {id, count} results; a monitor pops and
//                compares on every result handoff.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_match_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [CW-1:0]     res_count;
    logic              busy;

    serial_match_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_count (res_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int count;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp_v);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic push(input int id, input int count);
        exp_t e;
        e.id    = id;
        e.count = count;
        q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    bit             held = 1'b0;
    logic [IDW-1:0] held_id;
    logic [CW-1:0]  held_count;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (req_ready != '0) begin
                check($onehot0(req_ready), "req_ready_onehot", int'(req_ready), 0);
            end
            if (res_valid) begin
                if (held) begin
                    check(res_id == held_id && res_count == held_count, "res_stable",
                          int'({res_id, res_count}), int'({held_id, held_count}));
                end
                if (res_ready) begin
                    if (q.size() == 0) begin
                        check(1'b0, "unexpected_result", int'(res_id), -1);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check(int'(res_id) == e.id, "res_id", int'(res_id), e.id);
                        check(int'(res_count) == e.count, "res_count", int'(res_count), e.count);
                    end
                    held = 1'b0;
                end else begin
                    held       = 1'b1;
                    held_id    = res_id;
                    held_count = res_count;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_grant(output int idx);
        idx = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) idx = i;
                end
                return;
            end
        end
        check(1'b0, "grant_timeout", -1, 0);
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && q.size() != 0; c++) begin
            @(negedge clk);
        end
        check(q.size() == 0, "drain", q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int idx;
        int cyc;
        int order[5];
        order = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(busy == 1'b0 && res_valid == 1'b0 && req_ready == '0 && res_id == '0 && res_count == '0,
              "reset_outputs", int'({busy, res_valid, req_ready}), 0);
        rst_n = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check(busy == 1'b0 && res_valid == 1'b0 && req_ready == '0, "idle_quiet",
                  int'({busy, res_valid, req_ready}), 0);
        end

        // All four requesters valid: 0,1,2,3 then requester 0's second word.
        @(posedge clk); #1;
        req_data  = {8'h66, 8'h00, 8'hFF, 8'hAA};
        req_valid = 4'hF;
        push(0, 2); push(1, 0); push(2, 0); push(3, 2); push(0, 1);
        for (int k = 0; k < 5; k++) begin
            wait_grant(idx);
            check(idx == order[k], "grant_order", idx, order[k]);
            @(posedge clk); #1;
            if (k == 0) begin
                req_data[7:0] = 8'h02;
            end else if (idx >= 0) begin
                req_valid[idx] = 1'b0;
            end
        end
        req_valid = '0;
        drain();

        // Single requester 0, 8'hAA: timing of req_ready and res_valid.
        @(posedge clk); #1;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'hAA;
        push(0, 2);
        @(negedge clk);
        check(req_ready == 4'b0000, "ready_cycle0", int'(req_ready), 0);
        @(negedge clk);
        check(req_ready == 4'b0001, "ready_cycle1", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        cyc = 1;
        do begin
            @(negedge clk);
            cyc++;
        end while (!res_valid && cyc < 40);
        check(cyc == 10, "res_valid_cycle", cyc, 10);
        drain();

        // Stalled consumer: result held, no new grant until handoff.
        @(posedge clk); #1;
        res_ready       = 1'b0;
        req_valid[2]    = 1'b1;
        req_data[23:16] = 8'h66;
        push(2, 2);
        wait_grant(idx);
        check(idx == 2, "stall_grant", idx, 2);
        @(posedge clk); #1;
        req_valid[2]   = 1'b0;
        req_valid[1]   = 1'b1;
        req_data[15:8] = 8'h00;
        push(1, 0);
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check(res_valid == 1'b1, "stall_res_valid", int'(res_valid), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check(res_valid == 1'b1 && req_ready == '0, "stall_hold",
                  int'({res_valid, req_ready}), 16);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_grant(idx);
        check(idx == 1, "after_stall_grant", idx, 1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drain();

        // Reset in the middle of SHIFT; requester 0 stays pending.
        @(posedge clk); #1;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'hAA;
        wait_grant(idx);
        check(idx == 0, "pre_reset_grant", idx, 0);
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check(busy == 1'b0 && res_valid == 1'b0 && req_ready == '0 && res_id == '0 && res_count == '0,
              "mid_reset_outputs", int'({busy, res_valid, req_ready, res_id, res_count}), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(0, 2);
        wait_grant(idx);
        check(idx == 0, "post_reset_grant", idx, 0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        drain();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
